// File: rtl/ahb_arbiter_if.sv
// AHB arbitration handshake bundle: requests/locks/bus status in, grant/owner/lock out.
// master modport is the requester/bus side, slave modport is the arbiter side.
interface ahb_arbiter_if #(
  parameter int NUM_MASTER = 3
);
  logic [NUM_MASTER-1:0] HBUSREQ;
  logic [NUM_MASTER-1:0] HLOCK;
  logic [1:0]            HTRANS;
  logic [2:0]            HBURST;
  logic                  HREADY;
  logic [NUM_MASTER-1:0] HGRANT;
  logic [3:0]            HMASTER;
  logic                  HMASTLOCK;

  modport master (
    output HBUSREQ, HLOCK, HTRANS, HBURST, HREADY,
    input  HGRANT, HMASTER, HMASTLOCK
  );

  modport slave (
    input  HBUSREQ, HLOCK, HTRANS, HBURST, HREADY,
    output HGRANT, HMASTER, HMASTLOCK
  );
endinterface

// File: rtl/ahb_arbiter.sv
// Round-robin AHB-Lite arbiter: grant registered 1 cycle after a permitted edge, ownership 1 HREADY edge later.
// HREADY=0 freezes all state; fixed-length bursts and HLOCK block re-arbitration until the last beat.
module ahb_arbiter #(
  parameter int NUM_MASTER     = 3,
  parameter int DEFAULT_MASTER = 0
) (
  input logic          HCLK,
  input logic          HRESET,
  ahb_arbiter_if.slave bus
);
  localparam logic [3:0] DEF_IDX   = 4'(DEFAULT_MASTER);
  localparam logic [1:0] TR_IDLE   = 2'd0;
  localparam logic [1:0] TR_BUSY   = 2'd1;
  localparam logic [1:0] TR_NONSEQ = 2'd2;
  localparam logic [1:0] TR_SEQ    = 2'd3;

  logic [3:0]            gnt_q, gnt_d;
  logic [3:0]            hmaster_q, hmaster_d;
  logic [3:0]            left_q, left_d;
  logic [NUM_MASTER-1:0] hgrant_q, hgrant_d;
  logic                  hmastlock_q, hmastlock_d;

  logic [15:0] req_ext;
  logic [15:0] lock_ext;
  logic        lock_cur;
  logic [3:0]  burst_left;
  logic [3:0]  pick;
  logic        found;
  logic [4:0]  idx;

  assign req_ext  = 16'(bus.HBUSREQ);
  assign lock_ext = 16'(bus.HLOCK);
  assign lock_cur = lock_ext[gnt_q];

  // Remaining beats after a NONSEQ: len-1 for fixed-length bursts, 0 for SINGLE/INCR.
  always_comb begin
    burst_left = 4'd0;
    case (bus.HBURST)
      3'd2, 3'd3: burst_left = 4'd3;
      3'd4, 3'd5: burst_left = 4'd7;
      3'd6, 3'd7: burst_left = 4'd15;
      default:    burst_left = 4'd0;
    endcase
  end

  always_comb begin
    left_d = left_q;
    if (bus.HREADY) begin
      case (bus.HTRANS)
        TR_NONSEQ: left_d = burst_left;
        TR_SEQ:    left_d = (left_q != 4'd0) ? left_q - 4'd1 : 4'd0;
        TR_BUSY:   left_d = left_q;
        TR_IDLE:   left_d = 4'd0;
        default:   left_d = 4'd0;
      endcase
    end
  end

  // Search starts just after the current grant and wraps, so the holder is considered last.
  always_comb begin
    pick  = DEF_IDX;
    found = 1'b0;
    idx   = 5'd0;
    for (int k = 1; k <= NUM_MASTER; k++) begin
      idx = {1'b0, gnt_q} + 5'(k);
      if (idx >= 5'(NUM_MASTER)) begin
        idx = idx - 5'(NUM_MASTER);
      end
      if (!found && req_ext[idx[3:0]]) begin
        pick  = idx[3:0];
        found = 1'b1;
      end
    end
  end

  always_comb begin
    gnt_d       = gnt_q;
    hmaster_d   = hmaster_q;
    hmastlock_d = hmastlock_q;
    if (bus.HREADY) begin
      hmaster_d   = gnt_q;
      hmastlock_d = lock_cur;
      if (!lock_cur && (left_d <= 4'd1)) begin
        gnt_d = pick;
      end
    end
    hgrant_d = '0;
    for (int i = 0; i < NUM_MASTER; i++) begin
      hgrant_d[i] = (gnt_d == 4'(i));
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      gnt_q       <= DEF_IDX;
      hmaster_q   <= DEF_IDX;
      left_q      <= 4'd0;
      hmastlock_q <= 1'b0;
      hgrant_q    <= NUM_MASTER'(1) << DEFAULT_MASTER;
    end else begin
      gnt_q       <= gnt_d;
      hmaster_q   <= hmaster_d;
      left_q      <= left_d;
      hmastlock_q <= hmastlock_d;
      hgrant_q    <= hgrant_d;
    end
  end

  assign bus.HGRANT    = hgrant_q;
  assign bus.HMASTER   = hmaster_q;
  assign bus.HMASTLOCK = hmastlock_q;
endmodule

// File: tb/tb_ahb_arbiter.sv
// Two arbiters (parking on M0 and on M1) share one stimulus stream; a queue-based scoreboard
// compares their outputs against a transaction-level model of the arbitration rules.
module tb_ahb_arbiter;
  localparam int N = 3;

  logic HCLK = 1'b0;
  logic rst_i = 1'b1;
  logic [N-1:0] req_i = '0;
  logic [N-1:0] lock_i = '0;
  logic [1:0] trans_i = 2'd0;
  logic [2:0] burst_i = 3'd0;
  logic ready_i = 1'b1;

  always #5 HCLK = ~HCLK;

  ahb_arbiter_if #(.NUM_MASTER(N)) bus0 ();
  ahb_arbiter_if #(.NUM_MASTER(N)) bus1 ();

  assign bus0.HBUSREQ = req_i;
  assign bus0.HLOCK   = lock_i;
  assign bus0.HTRANS  = trans_i;
  assign bus0.HBURST  = burst_i;
  assign bus0.HREADY  = ready_i;
  assign bus1.HBUSREQ = req_i;
  assign bus1.HLOCK   = lock_i;
  assign bus1.HTRANS  = trans_i;
  assign bus1.HBURST  = burst_i;
  assign bus1.HREADY  = ready_i;

  ahb_arbiter #(.NUM_MASTER(N), .DEFAULT_MASTER(0)) dut0 (.HCLK(HCLK), .HRESET(rst_i), .bus(bus0));
  ahb_arbiter #(.NUM_MASTER(N), .DEFAULT_MASTER(1)) dut1 (.HCLK(HCLK), .HRESET(rst_i), .bus(bus1));

  typedef struct packed {
    logic [N-1:0] grant;
    logic [3:0]   master;
    logic         lock;
  } exp_t;

  exp_t exp_q0[$];
  exp_t exp_q1[$];

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state per arbiter: who holds the grant, who owns the address phase, beats left.
  int m_gnt[2];
  int m_own[2];
  int m_left[2];
  bit m_lck[2];
  int m_def[2] = '{0, 1};

  function automatic exp_t model_out(input int d);
    exp_t e;
    e.grant  = N'(1 << m_gnt[d]);
    e.master = 4'(m_own[d]);
    e.lock   = m_lck[d];
    return e;
  endfunction

  task automatic model_edge(input int d, input logic [N-1:0] req, input logic [N-1:0] lk,
                            input logic [1:0] tr, input logic [2:0] bu, input logic rdy,
                            input logic rs);
    int len, nl, old, winner;
    bit hit;
    if (rs) begin
      m_gnt[d] = m_def[d]; m_own[d] = m_def[d]; m_lck[d] = 0; m_left[d] = 0;
    end else if (rdy) begin
      len = (bu < 3'd2) ? 1 : (4 << ((int'(bu) - 2) / 2));
      case (tr)
        2'd2:    nl = len - 1;
        2'd3:    nl = (m_left[d] > 0) ? m_left[d] - 1 : 0;
        2'd1:    nl = m_left[d];
        default: nl = 0;
      endcase
      old = m_gnt[d];
      m_own[d] = old;
      m_lck[d] = lk[old];
      if (!lk[old] && nl <= 1) begin
        winner = m_def[d];
        hit = 0;
        for (int k = 1; k <= N; k++) begin
          if (!hit && req[(old + k) % N]) begin
            winner = (old + k) % N;
            hit = 1;
          end
        end
        m_gnt[d] = winner;
      end
      m_left[d] = nl;
    end
  endtask

  task automatic step(input logic [N-1:0] req, input logic [N-1:0] lk, input logic [1:0] tr,
                      input logic [2:0] bu, input logic rdy, input logic rs);
    @(negedge HCLK);
    req_i = req; lock_i = lk; trans_i = tr; burst_i = bu; ready_i = rdy; rst_i = rs;
    for (int d = 0; d < 2; d++) model_edge(d, req, lk, tr, bu, rdy, rs);
    exp_q0.push_back(model_out(0));
    exp_q1.push_back(model_out(1));
  endtask

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, got, want, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge HCLK);
      #1;
      if (exp_q0.size() > 0) begin
        e = exp_q0.pop_front();
        check("hgrant0", 8'(bus0.HGRANT), 8'(e.grant));
        check("hmaster0", 8'(bus0.HMASTER), 8'(e.master));
        check("hmastlock0", 8'(bus0.HMASTLOCK), 8'(e.lock));
      end
      if (exp_q1.size() > 0) begin
        e = exp_q1.pop_front();
        check("hgrant1", 8'(bus1.HGRANT), 8'(e.grant));
        check("hmaster1", 8'(bus1.HMASTER), 8'(e.master));
        check("hmastlock1", 8'(bus1.HMASTLOCK), 8'(e.lock));
      end
    end
  end

  initial begin : stimulus
    int budget;
    // reset and round-robin with every master requesting SINGLE transfers
    repeat (2) step(3'b000, 3'b000, 2'd0, 3'd0, 1'b1, 1'b1);
    repeat (7) step(3'b111, 3'b000, 2'd2, 3'd0, 1'b1, 1'b0);
    // INCR16 with a competing requester
    step(3'b011, 3'b000, 2'd2, 3'd7, 1'b1, 1'b0);
    repeat (15) step(3'b011, 3'b000, 2'd3, 3'd7, 1'b1, 1'b0);
    repeat (2) step(3'b010, 3'b000, 2'd0, 3'd0, 1'b1, 1'b0);
    // INCR4 with three wait states mid-burst
    step(3'b101, 3'b000, 2'd2, 3'd3, 1'b1, 1'b0);
    step(3'b101, 3'b000, 2'd3, 3'd3, 1'b1, 1'b0);
    repeat (3) step(3'b101, 3'b000, 2'd3, 3'd3, 1'b0, 1'b0);
    repeat (2) step(3'b101, 3'b000, 2'd3, 3'd3, 1'b1, 1'b0);
    step(3'b101, 3'b000, 2'd0, 3'd0, 1'b1, 1'b0);
    // steer grant to M2, then hold it locked against M0/M1
    repeat (3) step(3'b100, 3'b000, 2'd0, 3'd0, 1'b1, 1'b0);
    repeat (5) step(3'b111, 3'b100, 2'd2, 3'd0, 1'b1, 1'b0);
    repeat (3) step(3'b111, 3'b000, 2'd2, 3'd0, 1'b1, 1'b0);
    // parking, then a lone M1 request
    repeat (3) step(3'b000, 3'b000, 2'd0, 3'd0, 1'b1, 1'b0);
    repeat (3) step(3'b010, 3'b000, 2'd2, 3'd0, 1'b1, 1'b0);
    // reset in the middle of a locked INCR8
    step(3'b110, 3'b010, 2'd2, 3'd5, 1'b1, 1'b0);
    repeat (2) step(3'b110, 3'b010, 2'd3, 3'd5, 1'b1, 1'b0);
    repeat (2) step(3'b110, 3'b010, 2'd3, 3'd5, 1'b1, 1'b1);
    repeat (3) step(3'b110, 3'b000, 2'd2, 3'd0, 1'b1, 1'b0);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step(3'($urandom_range(0, 7)),
           ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'b000,
           2'($urandom_range(0, 3)),
           3'($urandom_range(0, 7)),
           ($urandom_range(0, 4) != 0),
           ($urandom_range(0, 299) == 0));
    end
    budget = 10;
    while ((exp_q0.size() > 0 || exp_q1.size() > 0) && budget > 0) begin
      @(posedge HCLK);
      budget--;
    end
    #2;
    if (exp_q0.size() > 0 || exp_q1.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d/%0d expectations left, expected 0/0", exp_q0.size(), exp_q1.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ahb_arbiter.md
# ahb_arbiter

Round-robin AHB bus arbiter that shares one AHB-Lite address/data path among up to 16 bus masters (e.g. several bfm_ahb instances plus DMA masters). It drives the HGRANT handshake, the HMASTER select for the external address/control mux, and HMASTLOCK. It never breaks fixed-length bursts and honours HLOCK. Idle grants park on a default master.

## Interface
- NUM_MASTER, 3, number of masters, legal 2..16
- DEFAULT_MASTER, 0, parking master index, 0..NUM_MASTER-1
- HCLK  in  1  bus clock, all logic on rising edge
- HRESET  in  1  synchronous, active-high reset
- HBUSREQ  in  NUM_MASTER  per-master bus request
- HLOCK  in  NUM_MASTER  per-master locked-transfer request
- HTRANS  in  2  muxed HTRANS of current address-phase owner (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3)
- HBURST  in  3  muxed HBURST of current owner (SINGLE=0, INCR=1, WRAP4=2, INCR4=3, WRAP8=4, INCR8=5, WRAP16=6, INCR16=7)
- HREADY  in  1  bus-wide transfer-complete
- HGRANT  out  NUM_MASTER  one-hot grant
- HMASTER  out  4  index of address-phase owner, drives address/control mux
- HMASTLOCK  out  1  current address phase is locked

## Operation
- State: grant index GNT (4 b), owner index HMASTER (4 b), beat counter LEFT (4 b, 0..15).
- All registers update only on rising HCLK with HREADY=1; with HREADY=0 everything holds (wait states freeze arbitration and counting).
- Burst tracking, at HREADY=1 edge:
  - HTRANS=NONSEQ: LEFT <= len-1, where len = 4/8/16 for WRAP/INCR4/8/16, else 0.
  - HTRANS=SEQ and LEFT>0: LEFT <= LEFT-1.
  - IDLE, or BUSY with LEFT=0: LEFT <= 0. BUSY with LEFT>0: hold.
- Arbitration is permitted at an HREADY=1 edge iff the new LEFT value is <=1 (grant moves during the last beat's address phase) and lock does not block.
- Lock: if HLOCK[GNT]=1 at the edge, GNT holds regardless of other requests.
- Selection when permitted: search indices GNT+1, GNT+2, … wrapping modulo NUM_MASTER, with GNT itself last. First one with HBUSREQ=1 wins. If none request, GNT <= DEFAULT_MASTER.
- HGRANT = one-hot decode of GNT, registered.
- Ownership handoff: at each HREADY=1 edge, HMASTER <= GNT and HMASTLOCK <= HLOCK[GNT] (values sampled before the edge). The newly granted master starts its address phase in the following cycle.
- Reset (any time, including mid-burst or mid-lock): GNT=HMASTER=DEFAULT_MASTER, HGRANT=1<<DEFAULT_MASTER, HMASTLOCK=0, LEFT=0.
- HBUSREQ/HLOCK bits at indices >= NUM_MASTER do not exist. HMASTER upper bits are 0 when NUM_MASTER<=8.

## Timing
- Request to grant: HBUSREQ high before edge E (HREADY=1, arbitration permitted) -> HGRANT high after E (1 cycle).
- Grant to ownership: HGRANT high plus HREADY=1 at edge E+1 -> HMASTER changes after E+1. Address phase from the new owner follows.
- Back-to-back handoff costs no idle cycle if the new owner drives NONSEQ right after HMASTER changes.
- INCR4 from M0 with no wait states, NONSEQ at cycle t: HGRANT may move after the edge ending t+2. HMASTER moves after the edge ending t+3 (last beat's address phase).
- Simultaneous requests from all masters: strict rotation, one grant change per permitted edge.
- Lock release: HLOCK[GNT] low before an edge -> arbitration resumes at that edge. HMASTLOCK drops one HREADY edge later.

## Test plan
- Reset: HRESET=1 for 2 cycles mid-INCR8 with DEFAULT_MASTER=0 -> HGRANT=3'b001, HMASTER=0, HMASTLOCK=0 on the first cycle after the reset edge.
- Round-robin, NUM_MASTER=3: all HBUSREQ=1, SINGLE NONSEQ each cycle, HREADY=1 -> HGRANT sequence 001→010→100→001, HMASTER trails by 1 cycle.
- Burst protection: M0 INCR16 with M1 requesting -> HGRANT stays 001 for 14 beats and changes to 010 after the 14th accepted SEQ. HMASTER=1 only after the 16th address phase.
- Wait states: insert 3 HREADY=0 cycles mid-INCR4 -> HGRANT, HMASTER and LEFT all frozen. Handoff is delayed exactly 3 cycles versus the no-wait case.
- Lock: M2 holds HLOCK=1 across 5 SINGLE transfers while M0 and M1 request -> HGRANT=100 throughout, HMASTLOCK=1. HLOCK drop -> grant goes to M0 next edge.
- Parking: all HBUSREQ=0 with DEFAULT_MASTER=1 -> HGRANT=010 after 1 cycle. The M1 request then keeps the grant without change.
